// File: rtl/axi_2_mem_pkg.sv
// Shared types for the AXI-to-memory slave: FSM states, response codes and
// the default AXI channel typedef set used when no codebase types are supplied.
package axi_2_mem_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    B_RESP,
    R_RESP
  } state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
  } def_aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } def_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } def_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
  } def_ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } def_r_chan_t;

  typedef struct packed {
    def_aw_chan_t aw;
    logic         aw_valid;
    def_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    def_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } def_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    def_b_chan_t b;
    logic        r_valid;
    def_r_chan_t r;
  } def_resp_t;

endpackage

// File: rtl/axi_2_mem_regfile.sv
// Word storage with one byte-strobed synchronous write port and one
// asynchronous read port; contents clear on reset.
module axi_2_mem_regfile #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned STRBW = DATAW / 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDXW  = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             we,
  input  logic [IDXW-1:0]  waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [STRBW-1:0] wstrb,
  input  logic [IDXW-1:0]  raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < STRBW; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_2_mem.sv
// Single-beat AXI slave in front of a small word memory. Bursts are drained
// and answered with SLVERR; one write and one read contend via a fair priority bit.
module axi_2_mem
  import axi_2_mem_pkg::*;
#(
  parameter int unsigned      ADDRW     = 32,
  parameter int unsigned      DATAW     = 32,
  parameter int unsigned      STRBW     = DATAW / 8,
  parameter int unsigned      MEM_DEPTH = 16,
  parameter logic [ADDRW-1:0] BASE_ADDR = '0,
  parameter type aw_chan_t  = def_aw_chan_t,
  parameter type w_chan_t   = def_w_chan_t,
  parameter type b_chan_t   = def_b_chan_t,
  parameter type ar_chan_t  = def_ar_chan_t,
  parameter type r_chan_t   = def_r_chan_t,
  parameter type axi_req_t  = def_req_t,
  parameter type axi_resp_t = def_resp_t
) (
  input  logic      clk_i,
  input  logic      srst_i,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int unsigned      IDXW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned      OFFW       = $clog2(STRBW);
  localparam logic [ADDRW-1:0] SPAN       = ADDRW'(MEM_DEPTH * STRBW);
  localparam logic [ADDRW-1:0] ALIGN_MASK = ADDRW'(STRBW - 1);

  // BASE_ADDR is word aligned, so alignment of the offset equals alignment of addr.
  function automatic logic addr_ok(input logic [ADDRW-1:0] addr);
    logic [ADDRW-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < SPAN) && ((off & ALIGN_MASK) == '0);
  endfunction

  function automatic logic [IDXW-1:0] addr_idx(input logic [ADDRW-1:0] addr);
    return IDXW'((addr - BASE_ADDR) >> OFFW);
  endfunction

  state_e                 state_q;
  logic                   prio_rd_q;
  logic                   aw_full, w_full;
  aw_chan_t               aw_slot;
  w_chan_t                w_slot;
  ar_chan_t               ar_c;
  logic                   b_vld_p0, r_vld_p0;
  b_chan_t                b_p0;
  r_chan_t                r_p0;
  logic [AXI_LEN_W-1:0]   beat_q, rlen_q;
  logic [DATAW-1:0]       rdata;

  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic w_drain, write_rdy, contended, grant, wr_ok, rd_ok;

  assign ar_c = axi_req_i.ar;

  // A burst keeps the W slot open until its last beat lands in it.
  assign w_drain   = aw_full & w_full & (aw_slot.len != '0) & ~w_slot.last;
  assign write_rdy = aw_full & w_full & ((aw_slot.len == '0) | w_slot.last);
  assign contended = (state_q == IDLE) & write_rdy & axi_req_i.ar_valid;
  assign grant     = (state_q == IDLE) & write_rdy & (~prio_rd_q | ~axi_req_i.ar_valid);

  assign aw_ready = ~srst_i & ~aw_full;
  assign w_ready  = ~srst_i & (~w_full | w_drain);
  assign ar_ready = ~srst_i & (state_q == IDLE) & ~grant;

  assign aw_hs = axi_req_i.aw_valid & aw_ready;
  assign w_hs  = axi_req_i.w_valid & w_ready;
  assign ar_hs = axi_req_i.ar_valid & ar_ready;
  assign b_hs  = (state_q == B_RESP) & axi_req_i.b_ready;
  assign r_hs  = (state_q == R_RESP) & axi_req_i.r_ready;

  assign wr_ok = (aw_slot.len == '0) & addr_ok(aw_slot.addr);
  assign rd_ok = (ar_c.len == '0) & addr_ok(ar_c.addr);

  axi_2_mem_regfile #(
    .DATAW (DATAW),
    .STRBW (STRBW),
    .DEPTH (MEM_DEPTH),
    .IDXW  (IDXW)
  ) i_regfile (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .we     (grant & wr_ok),
    .waddr  (addr_idx(aw_slot.addr)),
    .wdata  (w_slot.data),
    .wstrb  (w_slot.strb),
    .raddr  (addr_idx(ar_c.addr)),
    .rdata  (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (grant)      aw_full <= 1'b0;
      else if (aw_hs) aw_full <= 1'b1;
      if (grant)      w_full  <= 1'b0;
      else if (w_hs)  w_full  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) aw_slot <= axi_req_i.aw;
    if (w_hs)  w_slot  <= axi_req_i.w;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      prio_rd_q <= 1'b0;
      b_vld_p0  <= 1'b0;
      r_vld_p0  <= 1'b0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (contended) prio_rd_q <= ~prio_rd_q;
          if (grant) begin
            state_q  <= B_RESP;
            b_vld_p0 <= 1'b1;
          end else if (ar_hs) begin
            state_q  <= R_RESP;
            r_vld_p0 <= 1'b1;
            beat_q   <= '0;
          end
        end
        B_RESP: begin
          if (b_hs) begin
            state_q  <= IDLE;
            b_vld_p0 <= 1'b0;
          end
        end
        R_RESP: begin
          if (r_hs) begin
            if (r_p0.last) begin
              state_q  <= IDLE;
              r_vld_p0 <= 1'b0;
            end else begin
              beat_q <= beat_q + AXI_LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // p0: response payloads captured at grant / AR handshake, held until accepted
  always_ff @(posedge clk_i) begin
    if (grant) begin
      b_p0.id   <= aw_slot.id;
      b_p0.resp <= wr_ok ? OKAY : SLVERR;
    end
    if (ar_hs) begin
      r_p0.id   <= ar_c.id;
      r_p0.data <= rd_ok ? rdata : '0;
      r_p0.resp <= rd_ok ? OKAY : SLVERR;
      r_p0.last <= (ar_c.len == '0);
      rlen_q    <= ar_c.len;
    end else if (r_hs && !r_p0.last) begin
      r_p0.last <= ((beat_q + AXI_LEN_W'(1)) == rlen_q);
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_valid  = b_vld_p0 & ~srst_i;
    axi_resp_o.b        = b_p0;
    axi_resp_o.r_valid  = r_vld_p0 & ~srst_i;
    axi_resp_o.r        = r_p0;
  end

endmodule

// File: tb/tb_axi_2_mem.sv
// Directed bench for axi_2_mem: a transaction-level memory model predicts every
// B and R response, and a negedge monitor compares the DUT against it.
module tb_axi_2_mem;
  import axi_2_mem_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  def_aw_chan_t aw_s;
  def_w_chan_t  w_s;
  def_ar_chan_t ar_s;
  logic aw_valid_s = 0, w_valid_s = 0, ar_valid_s = 0, b_ready_s = 1, r_ready_s = 1;
  def_req_t  req;
  def_resp_t resp;

  always_comb begin
    req          = '0;
    req.aw       = aw_s;
    req.aw_valid = aw_valid_s;
    req.w        = w_s;
    req.w_valid  = w_valid_s;
    req.b_ready  = b_ready_s;
    req.ar       = ar_s;
    req.ar_valid = ar_valid_s;
    req.r_ready  = r_ready_s;
  end

  axi_2_mem dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .axi_req_i  (req),
    .axi_resp_o (resp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } exp_b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } exp_r_t;
  exp_b_t exp_b_q[$];
  exp_r_t exp_r_q[$];
  logic [31:0] mem_m [16];
  bit prio_wf = 1'b1;

  function automatic bit in_range(input logic [31:0] addr);
    return (addr < 32'd64) && (addr % 4 == 0);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] len, input logic [3:0] id);
    logic [1:0] rsp;
    rsp = SLVERR;
    if (len == 0 && in_range(addr)) begin
      rsp = OKAY;
      for (int b = 0; b < 4; b++) if (strb[b]) mem_m[addr / 4][8*b +: 8] = data[8*b +: 8];
    end
    exp_b_q.push_back('{id: id, resp: rsp});
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    if (len != 0) begin
      for (int i = 0; i <= int'(len); i++)
        exp_r_q.push_back('{id: id, data: 32'h0, resp: SLVERR, last: (i == int'(len))});
    end else if (in_range(addr)) begin
      exp_r_q.push_back('{id: id, data: mem_m[addr / 4], resp: OKAY, last: 1'b1});
    end else begin
      exp_r_q.push_back('{id: id, data: 32'h0, resp: SLVERR, last: 1'b1});
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] last_r_data;
  logic [1:0]  last_r_resp, last_b_resp;
  logic        last_r_last;
  int          r_beats = 0, r_lasts = 0;
  bit          b_stall = 0, r_stall = 0;
  def_b_chan_t b_prev;
  def_r_chan_t r_prev;
  exp_b_t      eb;
  exp_r_t      er;

  initial forever begin
    @(negedge clk);
    if (srst) begin
      chk("rst_aw_ready", resp.aw_ready, 0);
      chk("rst_w_ready", resp.w_ready, 0);
      chk("rst_ar_ready", resp.ar_ready, 0);
      chk("rst_b_valid", resp.b_valid, 0);
      chk("rst_r_valid", resp.r_valid, 0);
      b_stall = 0;
      r_stall = 0;
    end else begin
      if (b_stall) begin
        chk("b_hold_valid", resp.b_valid, 1);
        chk("b_hold_payload", resp.b, b_prev);
      end
      if (r_stall) begin
        chk("r_hold_valid", resp.r_valid, 1);
        chk("r_hold_payload", resp.r, r_prev);
      end
      if (resp.b_valid && b_ready_s) begin
        if (exp_b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected actual=id%0h/resp%0h required=no_response", resp.b.id, resp.b.resp);
        end else begin
          eb = exp_b_q.pop_front();
          chk("b_id", resp.b.id, eb.id);
          chk("b_resp", resp.b.resp, eb.resp);
          last_b_resp = resp.b.resp;
        end
      end
      if (resp.r_valid && r_ready_s) begin
        if (exp_r_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected actual=id%0h/data%0h required=no_response", resp.r.id, resp.r.data);
        end else begin
          er = exp_r_q.pop_front();
          chk("r_id", resp.r.id, er.id);
          chk("r_data", resp.r.data, er.data);
          chk("r_resp", resp.r.resp, er.resp);
          chk("r_last", resp.r.last, er.last);
          last_r_data = resp.r.data;
          last_r_resp = resp.r.resp;
          last_r_last = resp.r.last;
          r_beats++;
          if (resp.r.last) r_lasts++;
        end
      end
      b_stall = resp.b_valid && !b_ready_s;
      r_stall = resp.r_valid && !r_ready_s;
      b_prev  = resp.b;
      r_prev  = resp.r;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    aw_s.addr = addr; aw_s.len = len; aw_s.id = id; aw_valid_s = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp.aw_ready) begin @(posedge clk); #1; aw_valid_s = 0; return; end
    end
    aw_valid_s = 0; checks++; failures++;
    $display("FAIL aw_timeout actual=no_aw_ready required=aw_ready");
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    w_s.data = data; w_s.strb = strb; w_s.last = last; w_valid_s = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp.w_ready) begin @(posedge clk); #1; w_valid_s = 0; return; end
    end
    w_valid_s = 0; checks++; failures++;
    $display("FAIL w_timeout actual=no_w_ready required=w_ready");
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    ar_s.addr = addr; ar_s.len = len; ar_s.id = id; ar_valid_s = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp.ar_ready) begin @(posedge clk); #1; ar_valid_s = 0; return; end
    end
    ar_valid_s = 0; checks++; failures++;
    $display("FAIL ar_timeout actual=no_ar_ready required=ar_ready");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL response_timeout actual=b%0d/r%0d_pending required=0", exp_b_q.size(), exp_r_q.size());
      exp_b_q.delete(); exp_r_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] id);
    model_write(addr, data, strb, 8'd0, id);
    fork
      send_aw(addr, 8'd0, id);
      send_w(data, strb, 1'b1);
    join
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    model_read(addr, len, id);
    send_ar(addr, len, id);
    wait_idle();
  endtask

  task automatic contend(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] idw, input logic [3:0] idr);
    bit wf;
    wf = prio_wf;
    if (wf) begin model_write(addr, data, 4'hF, 8'd0, idw); model_read(addr, 8'd0, idr); end
    else    begin model_read(addr, 8'd0, idr); model_write(addr, data, 4'hF, 8'd0, idw); end
    prio_wf = !prio_wf;
    fork
      send_aw(addr, 8'd0, idw);
      send_w(data, 4'hF, 1'b1);
    join
    fork
      send_ar(addr, 8'd0, idr);
      begin @(negedge clk); chk("arb_ar_ready", resp.ar_ready, !wf); end
    join
    wait_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit stop;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    aw_s = '0; w_s = '0; ar_s = '0;
    repeat (3) @(posedge clk);
    #1 srst = 0;
    @(negedge clk);
    chk("post_rst_aw_ready", resp.aw_ready, 1);
    chk("post_rst_w_ready", resp.w_ready, 1);
    chk("post_rst_ar_ready", resp.ar_ready, 1);
    @(posedge clk); #1;

    // basic write then read
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 4'h1);
    chk("wr8_b_resp", last_b_resp, 2'b00);
    do_read(32'h8, 8'd0, 4'h2);
    chk("rd8_data", last_r_data, 32'hDEADBEEF);
    chk("rd8_last", last_r_last, 1);

    // W ahead of AW, partial strobe
    model_write(32'h4, 32'h11223344, 4'h3, 8'd0, 4'h3);
    chk("model_word1", mem_m[1], 32'h00003344);
    send_w(32'h11223344, 4'h3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_wait_no_b", resp.b_valid, 0);
      chk("w_wait_slot_full", resp.w_ready, 0);
    end
    @(posedge clk); #1;
    send_aw(32'h4, 8'd0, 4'h3);
    wait_idle();
    do_read(32'h4, 8'd0, 4'h4);
    chk("rd4_data", last_r_data, 32'h00003344);

    // arbitration: write first, then read first
    contend(32'hC, 32'hA5A5A5A5, 4'h5, 4'h6);
    chk("cont1_read", last_r_data, 32'hA5A5A5A5);
    contend(32'hC, 32'h5A5A5A5A, 4'h7, 4'h8);
    chk("cont2_read_old", last_r_data, 32'hA5A5A5A5);
    do_read(32'hC, 8'd0, 4'h9);
    chk("cont2_commit", last_r_data, 32'h5A5A5A5A);

    // range and alignment
    do_read(32'h40, 8'd0, 4'hA);
    chk("rd40_resp", last_r_resp, 2'b10);
    chk("rd40_data", last_r_data, 32'h0);
    do_write(32'h2, 32'hFFFFFFFF, 4'hF, 4'hB);
    chk("wr2_resp", last_b_resp, 2'b10);
    do_read(32'h0, 8'd0, 4'hC);
    chk("rd0_unchanged", last_r_data, 32'h0);
    do_read(32'h9, 8'd0, 4'hD);
    do_write(32'h3C, 32'hCAFEF00D, 4'hF, 4'hE);
    do_read(32'h3C, 8'd0, 4'hF);
    chk("rd3c_data", last_r_data, 32'hCAFEF00D);

    // read burst with back-pressure
    r_beats = 0; r_lasts = 0; stop = 0;
    model_read(32'h0, 8'd3, 4'h5);
    fork
      begin send_ar(32'h0, 8'd3, 4'h5); wait_idle(); stop = 1; end
      begin
        while (!stop) begin @(posedge clk); #1; r_ready_s = ~r_ready_s; end
        r_ready_s = 1;
      end
    join
    chk("burst_beats", r_beats, 4);
    chk("burst_lasts", r_lasts, 1);
    chk("burst_resp", last_r_resp, 2'b10);

    // write burst of two beats
    model_write(32'h14, 32'h0, 4'hF, 8'd1, 4'h6);
    fork
      send_aw(32'h14, 8'd1, 4'h6);
      begin send_w(32'h01010101, 4'hF, 1'b0); send_w(32'h02020202, 4'hF, 1'b1); end
    join
    wait_idle();
    chk("wburst_resp", last_b_resp, 2'b10);
    do_read(32'h14, 8'd0, 4'h7);
    chk("wburst_no_commit", last_r_data, 32'h0);

    // reset while a B is stalled
    b_ready_s = 0;
    model_write(32'h10, 32'h12345678, 4'hF, 8'd0, 4'h8);
    fork
      send_aw(32'h10, 8'd0, 4'h8);
      send_w(32'h12345678, 4'hF, 1'b1);
    join
    begin
      int n;
      n = 0;
      while (!resp.b_valid && n < 20) begin @(negedge clk); n++; end
    end
    chk("stall_b_valid", resp.b_valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    srst = 1;
    exp_b_q.delete(); exp_r_q.delete();
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    @(negedge clk);
    chk("rst_drop_b", resp.b_valid, 0);
    @(posedge clk); #1;
    srst = 0;
    @(negedge clk);
    chk("rel_aw_ready", resp.aw_ready, 1);
    chk("rel_w_ready", resp.w_ready, 1);
    chk("rel_ar_ready", resp.ar_ready, 1);
    b_ready_s = 1;
    repeat (10) @(negedge clk);
    chk("rst_no_late_b", resp.b_valid, 0);
    @(posedge clk); #1;
    do_read(32'h10, 8'd0, 4'h9);
    chk("rst_mem10", last_r_data, 32'h0);
    do_read(32'h8, 8'd0, 4'hA);
    chk("rst_mem8", last_r_data, 32'h0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
